// File: rtl/led_pkg.sv
// Shared definitions for the LED mode controller: mode encodings and
// small elaboration-time helpers for turning times into cycle counts.
package led_pkg;

  // LED modes, in the order a press steps through them.
  typedef enum logic [1:0] {
    MODE_OFF        = 2'd0,
    MODE_ON         = 2'd1,
    MODE_BLINK_FAST = 2'd2,
    MODE_BLINK_SLOW = 2'd3
  } mode_t;

  // Milliseconds to clock cycles.
  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Width of a counter that holds 0 .. n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Mode that follows m on a short press.
  function automatic mode_t next_mode(input mode_t m);
    mode_t r;
    r = MODE_OFF;
    case (m)
      MODE_OFF:        r = MODE_ON;
      MODE_ON:         r = MODE_BLINK_FAST;
      MODE_BLINK_FAST: r = MODE_BLINK_SLOW;
      MODE_BLINK_SLOW: r = MODE_OFF;
      default:         r = MODE_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_mode_ctrl_btn_debounce.sv
// btn_debounce: two-flop synchroniser, level debouncer and press detector
// for one active-low push-button.
//
// The synchroniser and the accepted level reset to 0 ("pressed"), so a
// button held through reset must be seen released before a press counts.
// press is a registered one-cycle pulse on the accepted 1->0 transition.
module btn_debounce
  import led_pkg::*;
#(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_raw,
  output logic stable,
  output logic press
);

  localparam int CW = cnt_w(DB_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn_n_raw;
      sync1 <= sync0;
    end
  end

  // Accept a new level only after it has differed for DB_CYC cycles in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync1;
        cnt    <= '0;
        press  <= ~sync1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: single-button LED mode controller.
//
// A debounced press steps the mode OFF -> ON -> BLINK_FAST -> BLINK_SLOW -> OFF.
// Blink modes start lit and toggle every HALF cycles of their own rate.
//
// Optional build macro LED_LONG_PRESS_EN: holding the button for LONG_MS
// forces the mode to OFF once per hold (after the normal press advance).
//
// state           | meaning
// ----------------+---------------------------------------------
// MODE_OFF        | led dark
// MODE_ON         | led lit
// MODE_BLINK_FAST | led toggles every FAST_HALF cycles, starts lit
// MODE_BLINK_SLOW | led toggles every SLOW_HALF cycles, starts lit
module led_mode_ctrl
  import led_pkg::*;
#(
  parameter int CLK_HZ      = 27000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int FAST_HZ     = 4,
  parameter int SLOW_HZ     = 1,
  parameter int LONG_MS     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn1,
  output logic       led,
  output logic [1:0] mode
);

  localparam int DB_CYC    = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int FAST_HALF = CLK_HZ / (2 * FAST_HZ);
  localparam int SLOW_HALF = CLK_HZ / (2 * SLOW_HZ);
  localparam int BLINK_MAX = (FAST_HALF > SLOW_HALF) ? FAST_HALF : SLOW_HALF;
  localparam int BW        = cnt_w(BLINK_MAX);

  localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);
  localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);

  logic          stable;
  logic          press;
  logic          long_hit;

  mode_t         state_q;
  mode_t         state_d;
  mode_t         adv_mode;
  logic          led_d;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_d;

  btn_debounce #(
    .DB_CYC (DB_CYC)
  ) u_btn (
    .clk       (clk),
    .rst       (rst),
    .btn_n_raw (btn1),
    .stable    (stable),
    .press     (press)
  );

`ifdef LED_LONG_PRESS_EN
  localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
  localparam int HW       = cnt_w(LONG_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYC - 2);

  logic [HW-1:0] hold_cnt;

  // Time how long the accepted level has been low; parks at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (stable) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_LAST) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  // Fires on the single cycle the hold counter steps onto its last value.
  assign long_hit = ~stable & (hold_cnt == HOLD_FIRE);
`else
  // Long press not built; keep the otherwise idle debounce level and
  // LONG_MS referenced in one place.
  logic unused;
  assign unused   = &{1'b0, stable, (LONG_MS > 0)};
  assign long_hit = 1'b0;
`endif

  assign adv_mode = next_mode(state_q);

  // Mode, LED and blink counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MODE_OFF;
      led       <= 1'b0;
      blink_cnt <= '0;
    end else begin
      state_q   <= state_d;
      led       <= led_d;
      blink_cnt <= blink_cnt_d;
    end
  end

  // Next mode and LED: long hold beats press, press beats a due blink toggle.
  always_comb begin
    state_d     = state_q;
    led_d       = led;
    blink_cnt_d = blink_cnt;
    if (long_hit) begin
      state_d     = MODE_OFF;
      led_d       = 1'b0;
      blink_cnt_d = '0;
    end else if (press) begin
      state_d     = adv_mode;
      led_d       = (adv_mode != MODE_OFF);
      blink_cnt_d = '0;
    end else begin
      case (state_q)
        MODE_OFF: begin
          led_d       = 1'b0;
          blink_cnt_d = '0;
        end
        MODE_ON: begin
          led_d       = 1'b1;
          blink_cnt_d = '0;
        end
        MODE_BLINK_FAST: begin
          if (blink_cnt == FAST_LAST) begin
            led_d       = ~led;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt + BW'(1);
          end
        end
        MODE_BLINK_SLOW: begin
          if (blink_cnt == SLOW_LAST) begin
            led_d       = ~led;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt + BW'(1);
          end
        end
        default: begin
          state_d     = MODE_OFF;
          led_d       = 1'b0;
          blink_cnt_d = '0;
        end
      endcase
    end
  end

  assign mode = state_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: directed scenarios with literal expectations plus
// a randomized button phase, all compared every cycle against a behavioural
// model built from timing rules (sample history window, elapsed-time blink).
// Honors LED_LONG_PRESS_EN when defined for the build.
module tb_led_mode_ctrl;

  localparam int CLK_HZ      = 1000;
  localparam int DEBOUNCE_MS = 4;
  localparam int FAST_HZ     = 100;
  localparam int SLOW_HZ     = 25;
  localparam int LONG_MS     = 50;

  localparam int DB        = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int FAST_HALF = CLK_HZ / (2 * FAST_HZ);
  localparam int SLOW_HALF = CLK_HZ / (2 * SLOW_HZ);
  localparam int LONG_CYC  = CLK_HZ / 1000 * LONG_MS;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       btn1 = 1'b1;
  logic       led;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  led_mode_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .FAST_HZ     (FAST_HZ),
    .SLOW_HZ     (SLOW_HZ),
    .LONG_MS     (LONG_MS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn1 (btn1),
    .led  (led),
    .mode (mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int n;            // clock edges since reset release
  int hist[$];      // btn1 samples, newest first
  int st_m;         // accepted button level
  int m_mode;
  int entry;        // edge on which the current mode was entered
  bit press_pend;   // accepted press, mode moves on the following edge
  int fall_edge;    // edge on which the accepted level last went low

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0;
      hist.delete();
      for (int i = 0; i < DB + 2; i++) hist.push_back(0);
      st_m       = 0;
      m_mode     = 0;
      entry      = 0;
      press_pend = 0;
      fall_edge  = 0;
    end else begin
      bit all_diff;
      n++;
      if (press_pend) begin
        m_mode     = (m_mode + 1) % 4;
        entry      = n;
        press_pend = 0;
      end
`ifdef LED_LONG_PRESS_EN
      if (st_m == 0 && n == fall_edge + LONG_CYC - 1) m_mode = 0;
`endif
      hist.push_front(int'(btn1));
      void'(hist.pop_back());
      // Level seen after the 2-flop delay must differ for DB edges running.
      all_diff = 1'b1;
      for (int i = 2; i < DB + 2; i++)
        if (hist[i] == st_m) all_diff = 1'b0;
      if (all_diff) begin
        st_m = 1 - st_m;
        if (st_m == 0) begin
          press_pend = 1;
          fall_edge  = n;
        end
      end
    end
  end

  function automatic int exp_led();
    int r;
    r = 0;
    case (m_mode)
      0: r = 0;
      1: r = 1;
      2: r = (((n - entry) / FAST_HALF) % 2 == 0) ? 1 : 0;
      default: r = (((n - entry) / SLOW_HALF) % 2 == 0) ? 1 : 0;
    endcase
    return r;
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_mode", int'(mode), m_mode);
      chk("model_led", int'(led), exp_led());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic rst_on();
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic rst_off();
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic press_clean();
    btn1 = 1'b0;
    wait_neg(10);
    btn1 = 1'b1;
    wait_neg(10);
  endtask

  int long_exp;

  initial begin
`ifdef LED_LONG_PRESS_EN
    long_exp = 0;
`else
    long_exp = 3;
`endif
    btn1 = 1'b1;
    wait_neg(3);
    rst_off();
    wait_neg(10);
    chk("reset_mode", int'(mode), 0);
    chk("reset_led", int'(led), 0);

    // press 1: OFF -> ON, visible 7 cycles after the falling edge
    btn1 = 1'b0; wait_neg(7);
    chk("p1_mode", int'(mode), 1);
    chk("p1_led", int'(led), 1);
    wait_neg(3); btn1 = 1'b1; wait_neg(10);

    // press 2: ON -> BLINK_FAST, high 5 then low 5 then high
    btn1 = 1'b0; wait_neg(7);
    chk("p2_mode", int'(mode), 2);
    chk("fast_led_start", int'(led), 1);
    wait_neg(3); btn1 = 1'b1; wait_neg(2);
    chk("fast_led_t5", int'(led), 0);
    wait_neg(5);
    chk("fast_led_t10", int'(led), 1);
    wait_neg(5);

    // press 3: BLINK_FAST -> BLINK_SLOW, high 20 then low
    btn1 = 1'b0; wait_neg(7);
    chk("p3_mode", int'(mode), 3);
    chk("slow_led_start", int'(led), 1);
    wait_neg(3); btn1 = 1'b1; wait_neg(16);
    chk("slow_led_t19", int'(led), 1);
    wait_neg(1);
    chk("slow_led_t20", int'(led), 0);

    // press 4: BLINK_SLOW -> OFF
    btn1 = 1'b0; wait_neg(7);
    chk("p4_mode", int'(mode), 0);
    chk("p4_led", int'(led), 0);
    wait_neg(3); btn1 = 1'b1; wait_neg(10);

    // bounce then settle low: one press only
    btn1 = 1'b0; wait_neg(1);
    btn1 = 1'b1; wait_neg(1);
    btn1 = 1'b0; wait_neg(15);
    chk("bounce_mode", int'(mode), 1);
    btn1 = 1'b1; wait_neg(10);
    chk("bounce_release_mode", int'(mode), 1);

    // 3-cycle low glitch is ignored
    btn1 = 1'b0; wait_neg(3);
    btn1 = 1'b1; wait_neg(15);
    chk("glitch_mode", int'(mode), 1);

    // enter BLINK_FAST, then press so the mode change lands on a due toggle
    btn1 = 1'b0; wait_neg(7);
    chk("col_fast_mode", int'(mode), 2);
    wait_neg(3); btn1 = 1'b1; wait_neg(15);
    btn1 = 1'b0; wait_neg(6);
    chk("col_pre_led", int'(led), 1);
    wait_neg(1);
    chk("col_mode", int'(mode), 3);
    chk("col_led", int'(led), 1);
    wait_neg(3); btn1 = 1'b1; wait_neg(16);
    chk("col_led_t19", int'(led), 1);
    wait_neg(1);
    chk("col_led_t20", int'(led), 0);

    // long hold from BLINK_FAST
    press_clean(); press_clean(); press_clean();
    chk("hold_start_mode", int'(mode), 2);
    btn1 = 1'b0; wait_neg(7);
    chk("hold_adv_mode", int'(mode), 3);
    wait_neg(47);
    chk("hold_pre_mode", int'(mode), 3);
    wait_neg(1);
    chk("hold_fire_mode", int'(mode), long_exp);
    wait_neg(5);
    chk("hold_still_mode", int'(mode), long_exp);
    btn1 = 1'b1; wait_neg(10);
    chk("hold_release_mode", int'(mode), long_exp);

    // button held low through reset release
    btn1 = 1'b0;
    rst_on();
    wait_neg(2);
    chk("in_reset_mode", int'(mode), 0);
    chk("in_reset_led", int'(led), 0);
    rst_off();
    wait_neg(20);
    btn1 = 1'b1; wait_neg(20);
    chk("held_reset_mode", int'(mode), 0);
    btn1 = 1'b0; wait_neg(7);
    chk("after_held_mode", int'(mode), 1);
    wait_neg(3); btn1 = 1'b1; wait_neg(10);

    // randomized button activity, with one reset in the middle
    for (int k = 0; k < 250; k++) begin
      btn1 = 1'($urandom_range(0, 1));
      wait_neg($urandom_range(1, 30));
      if (k == 140) begin
        rst_on();
        wait_neg(1);
        chk("mid_reset_mode", int'(mode), 0);
        chk("mid_reset_led", int'(led), 0);
        rst_off();
      end
    end
    wait_neg(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Board-level LED controller driven by a single push-button. It synchronises and debounces the raw button and detects presses. A mode state machine then cycles the LED through OFF, ON, fast blink and slow blink. It sits between the board button pin and the LED pin and replaces raw button-edge toggling.

Parameters:
CLK_HZ, 27000000, system clock frequency in Hz
DEBOUNCE_MS, 20, stable time required before a button level is accepted
FAST_HZ, 4, fast blink frequency in Hz
SLOW_HZ, 1, slow blink frequency in Hz
LONG_MS, 1000, hold time for a long press (only used with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn1  input  1  raw button, active-low (0 = pressed), asynchronous to clk
led  output  1  LED drive, 1 = lit, registered
mode  output  2  current mode: 0 OFF, 1 ON, 2 BLINK_FAST, 3 BLINK_SLOW, registered

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- Derived constants:
  - DB_CYC = CLK_HZ/1000*DEBOUNCE_MS
  - FAST_HALF = CLK_HZ/(2*FAST_HZ)
  - SLOW_HALF = CLK_HZ/(2*SLOW_HZ)
  - LONG_CYC = CLK_HZ/1000*LONG_MS
  - All counters are sized with $clog2 of their maximum. No counter wraps; each saturates or is cleared.
- Reset values:
  - led=0, mode=OFF, blink counter=0.
  - Synchroniser flops and debounced level reset to 0 ("pressed"), so a button held through reset release never produces a press. The first press is only accepted after a debounced release.
- Synchroniser: two flops on btn1.
- Debounce:
  - Counter clears whenever the synced level equals the stable level.
  - Otherwise the counter increments. When it reaches DB_CYC-1 while the level still differs, stable takes the synced level and the counter clears.
  - Glitches shorter than DB_CYC cycles are ignored.
- Press pulse:
  - One-cycle pulse when stable goes 1->0.
  - Latency from a clean btn1 falling edge to the pulse is 2+DB_CYC cycles (±1).
  - Release produces no action.
- Mode FSM: on each press pulse, OFF->ON->BLINK_FAST->BLINK_SLOW->OFF. The state updates the cycle after the pulse.
- LED output:
  - OFF: led=0.
  - ON: led=1.
  - Blink modes:
    - On entering either blink state, led=1 and the blink counter clears in the same update.
    - The counter counts to HALF-1 for that mode, then led toggles and the counter clears.
    - BLINK_FAST->BLINK_SLOW restarts the counter and sets led=1.
- Simultaneous events: a press on the same cycle as a blink toggle wins; the mode advances and led follows the new mode's entry rule.
- Reset mid-operation: all state returns immediately to reset values; no partial blink period is completed.

Optional Feature:
LED_LONG_PRESS_EN
- Defined:
  - A hold counter runs while stable==0 and clears on release.
  - On reaching LONG_CYC-1, mode is forced to OFF (led=0) once per hold. The counter saturates, so continued holding does nothing further.
  - The short-press advance at press start still happens first.
- Undefined: no hold counter is built; LONG_MS is unused; holding has no effect beyond the initial press.

Decomposition:
- Shared package led_pkg holds:
  - mode encodings MODE_OFF/ON/BLINK_FAST/BLINK_SLOW (2-bit)
  - a helper function for ms-to-cycles conversion
- One natural sub-module, btn_debounce: synchroniser, debounce counter and press pulse.
  - Parameters: DB_CYC.
  - Ports: clk, rst, btn_n_raw, stable, press.
  - Reused for future buttons.
- The top level holds the FSM, blink counter and optional hold counter.

Test Plan:
Sim parameters: CLK_HZ=1000, DEBOUNCE_MS=4 (DB_CYC=4), FAST_HZ=100 (FAST_HALF=5), SLOW_HZ=25 (SLOW_HALF=20), LONG_MS=50.
- Reset, btn1 held 1 -> led=0, mode=0. After a clean press (btn1=0 for 10 cycles), mode=1 and led=1 within 7 cycles of the edge.
- Four clean presses, each followed by a release of 10 cycles -> mode sequence 1,2,3,0. In mode 2 led toggles every 5 cycles starting high; in mode 3 every 20 cycles.
- Bounce: btn1 toggles every cycle for 3 cycles, then settles at 0 -> exactly one press and mode advances by 1. A 3-cycle low glitch -> no change.
- btn1=0 held through rst deassertion for 20 cycles, then released -> mode stays 0 until the next clean press.
- Press during mode 2 on the exact cycle a toggle is due -> mode=3, led=1, next toggle 20 cycles later.
- With LED_LONG_PRESS_EN: from mode 2, hold btn1=0 for 60 cycles -> mode goes to 3, then to 0 about 50 cycles after stable low. No further change while held; without the macro, mode stays 3.
